// File: rtl/axi_master_pkg.sv
// Shared types and constants for the CPU-side AXI4 master port.
// Widths mirror the AXI_define.svh values used across the interconnect.
package axi_master_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_LEN_BITS  = 4;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_STRB_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // CPU request as captured on acceptance
    typedef struct packed {
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_DATA_BITS-1:0] wdata;
        logic [AXI_STRB_BITS-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/axi_cpu_master.sv
// CPU-to-AXI4 master: one outstanding read (AR/R) or single-beat write (AW/W/B).
// Define AXI_CPU_MASTER_BURST_EN to allow multi-beat reads of up to MAX_LEN+1 beats.
module axi_cpu_master
    import axi_master_pkg::*;
#(
    parameter int unsigned MASTER_ID = 0,
    parameter int unsigned MAX_LEN   = 3
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AXI_ADDR_BITS-1:0] req_addr,
    input  logic [AXI_DATA_BITS-1:0] req_wdata,
    input  logic [AXI_STRB_BITS-1:0] req_wstrb,
    input  logic [AXI_LEN_BITS-1:0]  req_len,
    output logic                     resp_valid,
    output logic [AXI_DATA_BITS-1:0] resp_rdata,
    output logic                     resp_last,
    output logic                     resp_err,
    output logic [AXI_ID_BITS-1:0]   AWID,
    output logic [AXI_ADDR_BITS-1:0] AWADDR,
    output logic [AXI_LEN_BITS-1:0]  AWLEN,
    output logic [2:0]               AWSIZE,
    output logic [1:0]               AWBURST,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [AXI_DATA_BITS-1:0] WDATA,
    output logic [AXI_STRB_BITS-1:0] WSTRB,
    output logic                     WLAST,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [AXI_ID_BITS-1:0]   BID,
    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    output logic                     BREADY,
    output logic [AXI_ID_BITS-1:0]   ARID,
    output logic [AXI_ADDR_BITS-1:0] ARADDR,
    output logic [AXI_LEN_BITS-1:0]  ARLEN,
    output logic [2:0]               ARSIZE,
    output logic [1:0]               ARBURST,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [AXI_ID_BITS-1:0]   RID,
    input  logic [AXI_DATA_BITS-1:0] RDATA,
    input  logic [1:0]               RRESP,
    input  logic                     RLAST,
    input  logic                     RVALID,
    output logic                     RREADY
);

    localparam logic [AXI_ID_BITS-1:0] MID = AXI_ID_BITS'(MASTER_ID);

    state_e                   state_q, state_d;
    req_t                     req_q, req_d;
    logic                     rdy_q, rdy_d;
    logic                     arvalid_q, arvalid_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     rready_q, rready_d;
    logic                     bready_q, bready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_last_q, resp_last_d;
    logic                     resp_err_q, resp_err_d;
    logic [AXI_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                     len_err_c;
    logic [AXI_LEN_BITS-1:0]  arlen_c;

`ifdef AXI_CPU_MASTER_BURST_EN
    localparam logic [AXI_LEN_BITS-1:0] MAX_LEN_C = AXI_LEN_BITS'(MAX_LEN);

    logic [AXI_LEN_BITS-1:0] arlen_q, arlen_d;
    logic [AXI_LEN_BITS-1:0] beat_q, beat_d;

    // Beat count must reach ARLEN exactly when RLAST shows up
    assign len_err_c = RLAST ? (beat_q != arlen_q) : (beat_q >= arlen_q);
    assign arlen_c   = arlen_q;
`else
    logic unused_len;

    assign unused_len = ^{req_len, MAX_LEN};
    assign len_err_c  = !RLAST;
    assign arlen_c    = '0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        arvalid_d    = arvalid_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_last_d  = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
`ifdef AXI_CPU_MASTER_BURST_EN
        arlen_d      = arlen_q;
        beat_d       = beat_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && rdy_q) begin
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.wstrb = req_wstrb;
                    if (req_write) begin
                        state_d   = AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = AR;
                        arvalid_d = 1'b1;
`ifdef AXI_CPU_MASTER_BURST_EN
                        arlen_d   = (req_len > MAX_LEN_C) ? MAX_LEN_C : req_len;
                        beat_d    = '0;
`endif
                    end
                end
            end
            AR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = R;
                end
            end
            R: begin
                if (RVALID && rready_q) begin
                    resp_valid_d = 1'b1;
                    rdata_d      = RDATA;
                    resp_last_d  = RLAST;
                    resp_err_d   = (RRESP != RESP_OKAY) || (RID != MID) || len_err_c;
`ifdef AXI_CPU_MASTER_BURST_EN
                    beat_d       = (beat_q == '1) ? beat_q : beat_q + AXI_LEN_BITS'(1);
`endif
                    if (RLAST) begin
                        state_d = IDLE;
                    end
                end
            end
            AW_W: begin
                // Address and data channels complete independently
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = B;
                end
            end
            B: begin
                if (BVALID && bready_q) begin
                    resp_valid_d = 1'b1;
                    resp_last_d  = 1'b1;
                    resp_err_d   = (BRESP != RESP_OKAY) || (BID != MID);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rdy_d    = (state_d == IDLE);
        rready_d = (state_d == R);
        bready_d = (state_d == B);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            rdy_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rready_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
`ifdef AXI_CPU_MASTER_BURST_EN
            arlen_q      <= '0;
            beat_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rdy_q        <= rdy_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rready_q     <= rready_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
`ifdef AXI_CPU_MASTER_BURST_EN
            arlen_q      <= arlen_d;
            beat_q       <= beat_d;
`endif
        end
    end

    assign req_ready  = rdy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_last  = resp_last_q;
    assign resp_err   = resp_err_q;

    assign AWID    = MID;
    assign AWADDR  = req_q.addr;
    assign AWLEN   = '0;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = awvalid_q;
    assign WDATA   = req_q.wdata;
    assign WSTRB   = req_q.wstrb;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

    assign ARID    = MID;
    assign ARADDR  = req_q.addr;
    assign ARLEN   = arlen_c;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule

// File: tb/tb_axi_cpu_master.sv
// Scoreboard bench for axi_cpu_master: directed AXI slave stimulus, queued expected responses.
module tb_axi_cpu_master;
    import axi_master_pkg::*;

    logic                     ACLK = 1'b0;
    logic                     ARESETn;
    logic                     req_valid, req_ready, req_write;
    logic [31:0]              req_addr, req_wdata;
    logic [3:0]               req_wstrb;
    logic [AXI_LEN_BITS-1:0]  req_len;
    logic                     resp_valid, resp_last, resp_err;
    logic [31:0]              resp_rdata;
    logic [AXI_ID_BITS-1:0]   AWID, BID, ARID, RID;
    logic [31:0]              AWADDR, WDATA, ARADDR, RDATA;
    logic [AXI_LEN_BITS-1:0]  AWLEN, ARLEN;
    logic [2:0]               AWSIZE, ARSIZE;
    logic [1:0]               AWBURST, ARBURST, BRESP, RRESP;
    logic                     AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic                     ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]               WSTRB;

    typedef struct {
        logic        chk_data;
        logic [31:0] rdata;
        logic        last;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 ACLK = ~ACLK;

    axi_cpu_master #(.MASTER_ID(0), .MAX_LEN(3)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last), .resp_err(resp_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic expect_resp(input logic cd, input logic [31:0] d, input logic l, input logic e);
        exp_t x;
        x.chk_data = cd;
        x.rdata    = d;
        x.last     = l;
        x.err      = e;
        exp_q.push_back(x);
    endtask

    // Present one request for a single accepting edge, then scramble the CPU inputs
    task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [AXI_LEN_BITS-1:0] len);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        req_len   = len;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'hA5A5_A5A5;
        req_wstrb = 4'hF;
    endtask

    task automatic ar_hs();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [1:0] rr, input logic l,
                          input logic [AXI_ID_BITS-1:0] id);
        RVALID = 1'b1;
        RDATA  = d;
        RRESP  = rr;
        RLAST  = l;
        RID    = id;
        step();
        RVALID = 1'b0;
        RLAST  = 1'b0;
    endtask

    task automatic b_beat(input logic [1:0] br, input logic [AXI_ID_BITS-1:0] id);
        BVALID = 1'b1;
        BRESP  = br;
        BID    = id;
        step();
        BVALID = 1'b0;
    endtask

    // Monitor: every resp_valid cycle consumes exactly one expected entry
    always @(negedge ACLK) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_data) chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_last", 32'(resp_last), 32'(e.last));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    initial begin
        ARESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_len = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0; BID = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RID = '0;

        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_valids", {29'd0, ARVALID, AWVALID, WVALID}, 0);
        chk("rst_readies", {30'd0, RREADY, BREADY}, 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        ARESETn = 1'b1;
        step();
        chk("post_rst_req_ready", 32'(req_ready), 1);

        // Read 0x10, ARREADY delayed two cycles
        send_req(1'b0, 32'h10, 32'h0, 4'h0, '0);
        chk("rd1_arvalid", 32'(ARVALID), 1);
        chk("rd1_araddr", ARADDR, 32'h10);
        chk("rd1_req_ready", 32'(req_ready), 0);
        chk("rd1_arlen", 32'(ARLEN), 0);
        chk("rd1_arsize", 32'(ARSIZE), 32'd2);
        chk("rd1_arburst", 32'(ARBURST), 32'd1);
        chk("rd1_arid", 32'(ARID), 0);
        step();
        chk("rd1_arvalid_hold", 32'(ARVALID), 1);
        chk("rd1_araddr_hold", ARADDR, 32'h10);
        ar_hs();
        chk("rd1_arvalid_drop", 32'(ARVALID), 0);
        chk("rd1_rready", 32'(RREADY), 1);
        expect_resp(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        r_beat(32'hDEADBEEF, RESP_OKAY, 1'b1, '0);
        chk("rd1_resp_valid", 32'(resp_valid), 1);
        chk("rd1_rready_drop", 32'(RREADY), 0);
        chk("rd1_req_ready", 32'(req_ready), 1);
        step();
        chk("rd1_resp_pulse", 32'(resp_valid), 0);

        // Write 0x20, WREADY before AWREADY
        send_req(1'b1, 32'h20, 32'h12345678, 4'b0011, '0);
        chk("wr1_awvalid", 32'(AWVALID), 1);
        chk("wr1_wvalid", 32'(WVALID), 1);
        chk("wr1_awaddr", AWADDR, 32'h20);
        chk("wr1_wdata", WDATA, 32'h12345678);
        chk("wr1_wstrb", 32'(WSTRB), 32'h3);
        chk("wr1_wlast", 32'(WLAST), 1);
        chk("wr1_aw_fixed", {22'd0, AWLEN, AWSIZE, AWBURST, 1'b0}, {22'd0, 4'd0, 3'd2, 2'd1, 1'b0});
        WREADY = 1'b1;
        step();
        WREADY = 1'b0;
        chk("wr1_wvalid_drop", 32'(WVALID), 0);
        chk("wr1_awvalid_hold", 32'(AWVALID), 1);
        step();
        chk("wr1_awvalid_hold2", 32'(AWVALID), 1);
        chk("wr1_bready_early", 32'(BREADY), 0);
        AWREADY = 1'b1;
        step();
        AWREADY = 1'b0;
        chk("wr1_awvalid_drop", 32'(AWVALID), 0);
        chk("wr1_bready", 32'(BREADY), 1);
        expect_resp(1'b0, 32'h0, 1'b1, 1'b0);
        b_beat(RESP_OKAY, '0);
        chk("wr1_resp_valid", 32'(resp_valid), 1);
        chk("wr1_bready_drop", 32'(BREADY), 0);
        step();
        chk("wr1_resp_pulse", 32'(resp_valid), 0);

        // Write with both channels ready together, SLVERR response
        send_req(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, '0);
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        step();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        chk("wr2_valids_drop", {30'd0, AWVALID, WVALID}, 0);
        chk("wr2_bready", 32'(BREADY), 1);
        expect_resp(1'b0, 32'h0, 1'b1, 1'b1);
        b_beat(RESP_SLVERR, '0);
        chk("wr2_req_ready", 32'(req_ready), 1);

        // Read errors: DECERR, then RID mismatch
        send_req(1'b0, 32'h30, 32'h0, 4'h0, '0);
        ar_hs();
        expect_resp(1'b1, 32'h1111_2222, 1'b1, 1'b1);
        r_beat(32'h1111_2222, RESP_DECERR, 1'b1, '0);
        step();
        send_req(1'b0, 32'h34, 32'h0, 4'h0, '0);
        ar_hs();
        expect_resp(1'b1, 32'h3333_4444, 1'b1, 1'b1);
        r_beat(32'h3333_4444, RESP_OKAY, 1'b1, 4'd5);
        step();

        // Reset while reading, then a clean read
        send_req(1'b0, 32'h38, 32'h0, 4'h0, '0);
        ar_hs();
        chk("rst_mid_rready_before", 32'(RREADY), 1);
        ARESETn = 1'b0;
        step();
        chk("rst_mid_rready", 32'(RREADY), 0);
        chk("rst_mid_req_ready_low", 32'(req_ready), 0);
        ARESETn = 1'b1;
        step();
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk("rst_mid_arvalid", 32'(ARVALID), 0);
        send_req(1'b0, 32'h40, 32'h0, 4'h0, '0);
        chk("rst_new_araddr", ARADDR, 32'h40);
        ar_hs();
        expect_resp(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        r_beat(32'hCAFE_F00D, RESP_OKAY, 1'b1, '0);
        step();

        // Back-to-back: request held high across completion
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_len = '0;
        step();
        req_addr = 32'h60;
        chk("b2b_araddr1", ARADDR, 32'h50);
        ar_hs();
        expect_resp(1'b1, 32'h5555_0000, 1'b1, 1'b0);
        r_beat(32'h5555_0000, RESP_OKAY, 1'b1, '0);
        chk("b2b_req_ready_in_resp", 32'(req_ready), 1);
        chk("b2b_arvalid_in_resp", 32'(ARVALID), 0);
        step();
        req_valid = 1'b0;
        chk("b2b_arvalid2", 32'(ARVALID), 1);
        chk("b2b_araddr2", ARADDR, 32'h60);
        ar_hs();
        expect_resp(1'b1, 32'h6666_0000, 1'b1, 1'b0);
        r_beat(32'h6666_0000, RESP_OKAY, 1'b1, '0);
        step();

`ifdef AXI_CPU_MASTER_BURST_EN
        // Four-beat gapped burst
        send_req(1'b0, 32'h100, 32'h0, 4'h0, 4'd3);
        chk("bur_arlen", 32'(ARLEN), 32'd3);
        ar_hs();
        for (int i = 0; i < 4; i++) begin
            expect_resp(1'b1, 32'hB000_0000 + 32'(i), i == 3, 1'b0);
            r_beat(32'hB000_0000 + 32'(i), RESP_OKAY, i == 3, '0);
            if (i < 3) step();
        end
        chk("bur_req_ready", 32'(req_ready), 1);
        // Oversized length clamps; RLAST on the 2nd beat is premature
        send_req(1'b0, 32'h200, 32'h0, 4'h0, 4'd7);
        chk("bur_arlen_clamp", 32'(ARLEN), 32'd3);
        ar_hs();
        expect_resp(1'b1, 32'hC000_0000, 1'b0, 1'b0);
        r_beat(32'hC000_0000, RESP_OKAY, 1'b0, '0);
        expect_resp(1'b1, 32'hC000_0001, 1'b1, 1'b1);
        r_beat(32'hC000_0001, RESP_OKAY, 1'b1, '0);
        chk("bur_early_req_ready", 32'(req_ready), 1);
        chk("bur_early_rready", 32'(RREADY), 0);
`else
        // req_len is ignored without burst support
        send_req(1'b0, 32'h70, 32'h0, 4'h0, 4'd2);
        chk("nb_arlen", 32'(ARLEN), 0);
        ar_hs();
        expect_resp(1'b1, 32'h7777_0000, 1'b1, 1'b0);
        r_beat(32'h7777_0000, RESP_OKAY, 1'b1, '0);
        chk("nb_req_ready", 32'(req_ready), 1);
`endif

        repeat (3) step();
        chk("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
